// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and state encoding for the instruction fetch stage.
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] INST_STEP    = 32'd4;

    typedef enum logic {
        SEQ     = 1'b0,
        WAIT_DS = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for an instruction returned by the
// SRAM while ID is stalled. flush has priority over pop, pop over push.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic        full,
    output logic [31:0] dout
);

    // Occupancy flag and stored word
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full <= 1'b0;
            dout <= 32'h0;
        end else if (flush || pop) begin
            full <= 1'b0;
        end else if (push && !full) begin
            full <= 1'b1;
            dout <= din;
        end
    end

endmodule

// File: rtl/if_fetch_redirect.sv
// if_fetch_redirect: IF stage fetch PC generation with delayed-branch redirect,
// exception redirect and a one-entry skid buffer in front of ID.
// Optional build macro: PC_ALIGN_CHECK_EN (misaligned fetch PC raises adel_ID).
//
// state   | meaning
// SEQ     | sequential fetch, redirects from ID may be accepted
// WAIT_DS | redirect accepted, delay slot not yet fetched; target in pend_pc
module if_fetch_redirect
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        inst_sram_ready,
    input  logic        Branch_Jump,
    input  logic [31:0] BJ_address,
    input  logic        is_bj_ID,
    input  logic        stall_ID,
    input  logic        exc_redirect,
    input  logic [31:0] exc_address,
    output logic [31:0] PC_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID,
    output logic        is_ds_ID,
    output logic        adel_ID
);

    fetch_state_t state, next_state;
    logic [31:0]  fetch_pc, next_pc, pend_pc, next_pend;
    logic [31:0]  fetch_inst, skid_data;
    logic         en_r, skid_full, skid_push, skid_pop;
    logic         misaligned, adel_lock;
    logic         fetch_avail, fetch_done, redirect_acc;
    logic         ds_pend, ds_slot;

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = (fetch_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
    assign adel_lock  = 1'b0;
    assign adel_ID    = 1'b0;
`endif

    assign inst_sram_addr = fetch_pc;
    assign inst_sram_en   = en_r & ~skid_full & ~misaligned;

    // A misaligned PC completes on its own without waiting for the SRAM
    assign fetch_avail  = skid_full | (inst_sram_en & inst_sram_ready) | (misaligned & ~adel_lock);
    assign fetch_done   = fetch_avail & ~stall_ID & ~exc_redirect;
    assign fetch_inst   = skid_full ? skid_data : (misaligned ? 32'h0 : inst_sram_rdata);
    assign skid_push    = inst_sram_en & inst_sram_ready & stall_ID & ~exc_redirect;
    assign skid_pop     = fetch_done & skid_full;
    assign redirect_acc = Branch_Jump & valid_ID & ~stall_ID & (state == SEQ);
    assign ds_slot      = (is_bj_ID & valid_ID) | ds_pend | (state == WAIT_DS);

    fetch_skid_buf u_skid (
        .clk    (clk),
        .resetn (resetn),
        .flush  (exc_redirect),
        .push   (skid_push),
        .pop    (skid_pop),
        .din    (inst_sram_rdata),
        .full   (skid_full),
        .dout   (skid_data)
    );

    // Next fetch PC, pending target and redirect state
    always_comb begin
        next_state = state;
        next_pc    = fetch_pc;
        next_pend  = pend_pc;
        case (state)
            SEQ: begin
                if (redirect_acc) begin
                    if (fetch_done) begin
                        next_pc = BJ_address;
                    end else begin
                        next_pend  = BJ_address;
                        next_state = WAIT_DS;
                    end
                end else if (fetch_done) begin
                    next_pc = fetch_pc + INST_STEP;
                end
            end
            WAIT_DS: begin
                if (fetch_done) begin
                    next_pc    = pend_pc;
                    next_state = SEQ;
                end
            end
            default: next_state = SEQ;
        endcase
        if (fetch_done && misaligned) begin
            next_pc = fetch_pc;
        end
        if (exc_redirect) begin
            next_pc    = exc_address;
            next_pend  = 32'h0;
            next_state = SEQ;
        end
    end

    // Fetch PC, state and SRAM enable registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_VECTOR;
            pend_pc  <= 32'h0;
            state    <= SEQ;
            en_r     <= 1'b0;
        end else begin
            fetch_pc <= next_pc;
            pend_pc  <= next_pend;
            state    <= next_state;
            en_r     <= 1'b1;
        end
    end

    // ID stage registers: load on completion, bubble when nothing arrived, hold on stall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            PC_ID    <= 32'h0;
            inst_ID  <= 32'h0;
            valid_ID <= 1'b0;
            is_ds_ID <= 1'b0;
            ds_pend  <= 1'b0;
        end else if (exc_redirect) begin
            valid_ID <= 1'b0;
            is_ds_ID <= 1'b0;
            ds_pend  <= 1'b0;
        end else if (!stall_ID) begin
            if (fetch_done) begin
                PC_ID    <= fetch_pc;
                inst_ID  <= fetch_inst;
                valid_ID <= 1'b1;
                is_ds_ID <= ds_slot;
                ds_pend  <= 1'b0;
            end else begin
                valid_ID <= 1'b0;
                is_ds_ID <= 1'b0;
                ds_pend  <= ds_slot;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Misaligned fetch reports adel once, then fetch stays parked until an exception redirect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adel_ID   <= 1'b0;
            adel_lock <= 1'b0;
        end else if (exc_redirect) begin
            adel_ID   <= 1'b0;
            adel_lock <= 1'b0;
        end else if (!stall_ID) begin
            adel_ID <= fetch_done & misaligned;
            if (fetch_done && misaligned) begin
                adel_lock <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_redirect.sv
// tb_if_fetch_redirect: directed scenarios plus a randomized run checked against
// an instruction-stream model (program order, delay slots, exception targets).
module tb_if_fetch_redirect;
    import cpu_pkg::*;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_ready;
    logic        Branch_Jump;
    logic [31:0] BJ_address;
    logic        is_bj_ID;
    logic        stall_ID;
    logic        exc_redirect;
    logic [31:0] exc_address;
    logic [31:0] PC_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;
    logic        is_ds_ID;
    logic        adel_ID;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign inst_sram_rdata = mem_word(inst_sram_addr);

    if_fetch_redirect dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_sram_ready (inst_sram_ready),
        .Branch_Jump     (Branch_Jump),
        .BJ_address      (BJ_address),
        .is_bj_ID        (is_bj_ID),
        .stall_ID        (stall_ID),
        .exc_redirect    (exc_redirect),
        .exc_address     (exc_address),
        .PC_ID           (PC_ID),
        .inst_ID         (inst_ID),
        .valid_ID        (valid_ID),
        .is_ds_ID        (is_ds_ID),
        .adel_ID         (adel_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_sram_ready = 1'b1;
        Branch_Jump     = 1'b0;
        BJ_address      = 32'h0;
        is_bj_ID        = 1'b0;
        stall_ID        = 1'b0;
        exc_redirect    = 1'b0;
        exc_address     = 32'h0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        step();
    endtask

    task automatic advance_to(input logic [31:0] pc);
        int n;
        n = 0;
        while (!(valid_ID === 1'b1 && PC_ID === pc) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL advance_to got %h exp %h", PC_ID, pc);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (inst_sram_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rst_addr got %h exp %h", inst_sram_addr, 32'hBFC0_0000); end
        checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", inst_sram_en); end
        checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_ID); end
        checks++; if (PC_ID !== 32'h0 || inst_ID !== 32'h0) begin errors++; $display("FAIL rst_id got %h/%h exp 0/0", PC_ID, inst_ID); end
        checks++; if (is_ds_ID !== 1'b0 || adel_ID !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", is_ds_ID, adel_ID); end
        resetn = 1'b1;
        step();
        checks++; if (inst_sram_en !== 1'b1) begin errors++; $display("FAIL rel_en got %b exp 1", inst_sram_en); end
        step();
        checks++; if (valid_ID !== 1'b1 || PC_ID !== 32'hBFC0_0000) begin errors++; $display("FAIL first_fetch got %b/%h exp 1/%h", valid_ID, PC_ID, 32'hBFC0_0000); end
        checks++; if (inst_ID !== mem_word(32'hBFC0_0000)) begin errors++; $display("FAIL first_inst got %h exp %h", inst_ID, mem_word(32'hBFC0_0000)); end
        step();
        checks++; if (PC_ID !== 32'hBFC0_0004) begin errors++; $display("FAIL second_fetch got %h exp %h", PC_ID, 32'hBFC0_0004); end
    endtask

    task automatic test_branch_ready();
        do_reset();
        advance_to(32'hBFC0_0010);
        Branch_Jump = 1'b1; is_bj_ID = 1'b1; BJ_address = 32'hBFC0_0100;
        step();
        Branch_Jump = 1'b0; is_bj_ID = 1'b0;
        checks++; if (PC_ID !== 32'hBFC0_0014 || is_ds_ID !== 1'b1) begin errors++; $display("FAIL br_ds got %h/%b exp %h/1", PC_ID, is_ds_ID, 32'hBFC0_0014); end
        step();
        checks++; if (PC_ID !== 32'hBFC0_0100 || is_ds_ID !== 1'b0) begin errors++; $display("FAIL br_target got %h/%b exp %h/0", PC_ID, is_ds_ID, 32'hBFC0_0100); end
        step();
        checks++; if (PC_ID !== 32'hBFC0_0104) begin errors++; $display("FAIL br_after got %h exp %h", PC_ID, 32'hBFC0_0104); end
    endtask

    task automatic test_branch_wait();
        do_reset();
        advance_to(32'hBFC0_0010);
        inst_sram_ready = 1'b0;
        Branch_Jump = 1'b1; is_bj_ID = 1'b1; BJ_address = 32'hBFC0_0100;
        step();
        Branch_Jump = 1'b0; is_bj_ID = 1'b0;
        checks++; if (dut.state !== WAIT_DS) begin errors++; $display("FAIL wait_state got %0d exp %0d", dut.state, WAIT_DS); end
        checks++; if (inst_sram_addr !== 32'hBFC0_0014) begin errors++; $display("FAIL wait_addr got %h exp %h", inst_sram_addr, 32'hBFC0_0014); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL wait_bubble got %b exp 0", valid_ID); end
            step();
        end
        checks++; if (valid_ID !== 1'b0 || dut.state !== WAIT_DS) begin errors++; $display("FAIL wait_hold got %b/%0d exp 0/%0d", valid_ID, dut.state, WAIT_DS); end
        inst_sram_ready = 1'b1;
        step();
        checks++; if (valid_ID !== 1'b1 || PC_ID !== 32'hBFC0_0014 || is_ds_ID !== 1'b1) begin errors++; $display("FAIL wait_ds got %b/%h/%b exp 1/%h/1", valid_ID, PC_ID, is_ds_ID, 32'hBFC0_0014); end
        step();
        checks++; if (PC_ID !== 32'hBFC0_0100 || is_ds_ID !== 1'b0) begin errors++; $display("FAIL wait_target got %h/%b exp %h/0", PC_ID, is_ds_ID, 32'hBFC0_0100); end
    endtask

    task automatic test_stall_skid();
        do_reset();
        advance_to(32'hBFC0_0008);
        stall_ID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL skid_en got %b exp 0", inst_sram_en); end
            checks++; if (PC_ID !== 32'hBFC0_0008 || valid_ID !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%b exp %h/1", PC_ID, valid_ID, 32'hBFC0_0008); end
        end
        stall_ID = 1'b0;
        step();
        checks++; if (PC_ID !== 32'hBFC0_000C || inst_ID !== mem_word(32'hBFC0_000C)) begin errors++; $display("FAIL skid_deliver got %h/%h exp %h/%h", PC_ID, inst_ID, 32'hBFC0_000C, mem_word(32'hBFC0_000C)); end
        checks++; if (inst_sram_en !== 1'b1) begin errors++; $display("FAIL skid_en_back got %b exp 1", inst_sram_en); end
        step();
        checks++; if (PC_ID !== 32'hBFC0_0010) begin errors++; $display("FAIL skid_next got %h exp %h", PC_ID, 32'hBFC0_0010); end
        step();
        checks++; if (PC_ID !== 32'hBFC0_0014) begin errors++; $display("FAIL skid_next2 got %h exp %h", PC_ID, 32'hBFC0_0014); end
    endtask

    task automatic test_exc_wait();
        do_reset();
        advance_to(32'hBFC0_0010);
        inst_sram_ready = 1'b0;
        Branch_Jump = 1'b1; is_bj_ID = 1'b1; BJ_address = 32'hBFC0_0100;
        step();
        Branch_Jump = 1'b0; is_bj_ID = 1'b0;
        stall_ID = 1'b1; exc_redirect = 1'b1; exc_address = 32'hBFC0_0380;
        step();
        exc_redirect = 1'b0;
        checks++; if (dut.state !== SEQ || inst_sram_addr !== 32'hBFC0_0380) begin errors++; $display("FAIL exc_redir got %0d/%h exp %0d/%h", dut.state, inst_sram_addr, SEQ, 32'hBFC0_0380); end
        checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL exc_bubble got %b exp 0", valid_ID); end
        stall_ID = 1'b0; inst_sram_ready = 1'b1;
        step();
        checks++; if (PC_ID !== 32'hBFC0_0380 || is_ds_ID !== 1'b0 || valid_ID !== 1'b1) begin errors++; $display("FAIL exc_fetch got %h/%b/%b exp %h/0/1", PC_ID, is_ds_ID, valid_ID, 32'hBFC0_0380); end
        step();
        checks++; if (PC_ID !== 32'hBFC0_0384) begin errors++; $display("FAIL exc_next got %h exp %h", PC_ID, 32'hBFC0_0384); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        advance_to(32'hBFC0_0010);
        inst_sram_ready = 1'b0;
        Branch_Jump = 1'b1; is_bj_ID = 1'b1; BJ_address = 32'hBFC0_0100;
        step();
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (dut.state !== SEQ || inst_sram_addr !== 32'hBFC0_0000 || inst_sram_en !== 1'b0) begin errors++; $display("FAIL midrst got %0d/%h/%b exp %0d/%h/0", dut.state, inst_sram_addr, inst_sram_en, SEQ, 32'hBFC0_0000); end
        idle_inputs();
        step();
        resetn = 1'b1;
        step();
        step();
        checks++; if (valid_ID !== 1'b1 || PC_ID !== 32'hBFC0_0000) begin errors++; $display("FAIL midrst_fetch got %b/%h exp 1/%h", valid_ID, PC_ID, 32'hBFC0_0000); end
        step();
        checks++; if (PC_ID !== 32'hBFC0_0004) begin errors++; $display("FAIL midrst_next got %h exp %h", PC_ID, 32'hBFC0_0004); end
    endtask

    task automatic test_align();
        do_reset();
        advance_to(32'hBFC0_0010);
        Branch_Jump = 1'b1; is_bj_ID = 1'b1; BJ_address = 32'hBFC0_0102;
        step();
        Branch_Jump = 1'b0; is_bj_ID = 1'b0;
        checks++; if (PC_ID !== 32'hBFC0_0014 || is_ds_ID !== 1'b1) begin errors++; $display("FAIL al_ds got %h/%b exp %h/1", PC_ID, is_ds_ID, 32'hBFC0_0014); end
        checks++; if (inst_sram_addr !== 32'hBFC0_0102) begin errors++; $display("FAIL al_addr got %h exp %h", inst_sram_addr, 32'hBFC0_0102); end
`ifdef PC_ALIGN_CHECK_EN
        checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL al_en got %b exp 0", inst_sram_en); end
        inst_sram_ready = 1'b0;
        step();
        checks++; if (adel_ID !== 1'b1 || PC_ID !== 32'hBFC0_0102 || inst_ID !== 32'h0 || valid_ID !== 1'b1) begin errors++; $display("FAIL al_adel got %b/%h/%h/%b exp 1/%h/0/1", adel_ID, PC_ID, inst_ID, valid_ID, 32'hBFC0_0102); end
        inst_sram_ready = 1'b1;
        step();
        checks++; if (inst_sram_addr !== 32'hBFC0_0102 || valid_ID !== 1'b0) begin errors++; $display("FAIL al_park got %h/%b exp %h/0", inst_sram_addr, valid_ID, 32'hBFC0_0102); end
        exc_redirect = 1'b1; exc_address = 32'hBFC0_0380;
        step();
        exc_redirect = 1'b0;
        step();
        checks++; if (PC_ID !== 32'hBFC0_0380 || adel_ID !== 1'b0) begin errors++; $display("FAIL al_exc got %h/%b exp %h/0", PC_ID, adel_ID, 32'hBFC0_0380); end
`else
        step();
        checks++; if (PC_ID !== 32'hBFC0_0102 || inst_ID !== mem_word(32'hBFC0_0102) || adel_ID !== 1'b0) begin errors++; $display("FAIL al_plain got %h/%h/%b exp %h/%h/0", PC_ID, inst_ID, adel_ID, 32'hBFC0_0102, mem_word(32'hBFC0_0102)); end
`endif
    endtask

    // Model: next expected program-order PC, whether it is a delay slot, and a
    // taken-branch target to jump to after that delay slot.
    task automatic test_random();
        logic [31:0] exp_pc, tgt;
        logic        exp_ds, tgt_v, last_ds;
        logic        drv_br, drv_taken, drv_exc, drv_stall;
        int          idle_cnt, deliveries;
        do_reset();
        exp_pc = RESET_VECTOR; tgt = 32'h0;
        exp_ds = 1'b0; tgt_v = 1'b0; last_ds = 1'b0;
        idle_cnt = 0; deliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            drv_stall = ($urandom_range(0, 4) == 0);
            drv_exc   = ($urandom_range(0, 99) == 0);
            drv_br    = (valid_ID === 1'b1) && !last_ds && ($urandom_range(0, 3) == 0);
            drv_taken = drv_br && ($urandom_range(0, 1) == 1);
            inst_sram_ready = ($urandom_range(0, 9) < 7);
            stall_ID     = drv_stall;
            is_bj_ID     = drv_br;
            Branch_Jump  = drv_taken;
            BJ_address   = {16'hBFC0, 14'($urandom_range(0, 16383)), 2'b00};
            exc_redirect = drv_exc;
            exc_address  = 32'hBFC0_0380 + (32'($urandom_range(0, 15)) << 4);
            step();
            if (drv_exc) begin
                exp_pc = exc_address; exp_ds = 1'b0; tgt_v = 1'b0; last_ds = 1'b0;
                checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL rnd_exc_bubble got %b exp 0", valid_ID); end
                idle_cnt = 0;
            end else if (!drv_stall) begin
                if (drv_br) begin
                    exp_ds = 1'b1; tgt_v = drv_taken; tgt = BJ_address;
                end
                if (valid_ID === 1'b1) begin
                    checks++; if (PC_ID !== exp_pc) begin errors++; $display("FAIL rnd_pc got %h exp %h", PC_ID, exp_pc); end
                    checks++; if (inst_ID !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_inst got %h exp %h", inst_ID, mem_word(exp_pc)); end
                    checks++; if (is_ds_ID !== exp_ds) begin errors++; $display("FAIL rnd_ds got %b exp %b at %h", is_ds_ID, exp_ds, exp_pc); end
                    last_ds = exp_ds;
                    if (exp_ds && tgt_v) begin
                        exp_pc = tgt; tgt_v = 1'b0;
                    end else begin
                        exp_pc = exp_pc + 32'd4;
                    end
                    exp_ds = 1'b0;
                    deliveries++;
                    idle_cnt = 0;
                end else begin
                    idle_cnt++;
                end
            end else begin
                idle_cnt++;
            end
            if (idle_cnt > 60) begin
                checks++; errors++;
                $display("FAIL rnd_progress got %0d idle cycles exp <= 60", idle_cnt);
                break;
            end
        end
        checks++; if (deliveries < 500) begin errors++; $display("FAIL rnd_deliveries got %0d exp >= 500", deliveries); end
        idle_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_branch_ready();
        test_branch_wait();
        test_stall_skid();
        test_exc_wait();
        test_reset_mid_wait();
        test_align();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_redirect.md
IF_FETCH_REDIRECT -- requirements
Module: if_fetch_redirect

Interface
REQ-001 SHALL use one clock and one reset: the reset is asynchronous and active-low.
REQ-002 SHALL have ports: clk in 1 system clock; resetn in 1 async active-low reset.
REQ-003 SHALL have ports: inst_sram_en out 1; inst_sram_addr out 32; inst_sram_rdata in 32; inst_sram_ready in 1 (rdata valid for the current addr).
REQ-004 SHALL have ports: Branch_Jump in 1; BJ_address in 32 (ID redirect); is_bj_ID in 1 (ID holds any branch/jump); stall_ID in 1 (ID not advancing).
REQ-005 SHALL have ports: exc_redirect in 1; exc_address in 32.
REQ-006 SHALL have ports: PC_ID out 32; inst_ID out 32; valid_ID out 1; is_ds_ID out 1 (delay-slot flag); adel_ID out 1.

Function
REQ-007 SHALL hold fetch_pc in a register that drives inst_sram_addr directly.
REQ-008 SHALL complete a fetch on an edge with inst_sram_ready=1, stall_ID=0 and no pending exception: PC_ID<=fetch_pc, inst_ID<=rdata, valid_ID<=1; latency is 1 cycle from ready.
REQ-009 SHALL load valid_ID<=0 (bubble) on a non-stalled edge with inst_sram_ready=0, leaving fetch_pc unchanged.
REQ-010 SHALL hold all ID outputs and fetch_pc while stall_ID=1.
REQ-011 SHALL treat a redirect as accepted when Branch_Jump=1, valid_ID=1 and stall_ID=0; Branch_Jump SHALL be ignored otherwise.
REQ-012 SHALL use a state machine with states SEQ and WAIT_DS.
REQ-013 SHALL, in SEQ with a redirect accepted and the delay slot completing on the same edge, load fetch_pc<=BJ_address; the next fetch is the target.
REQ-014 SHALL, in SEQ with a redirect accepted but the delay slot not completing, latch BJ_address into pend_pc, hold fetch_pc, and go to WAIT_DS.
REQ-015 SHALL, in WAIT_DS, load fetch_pc<=pend_pc and return to SEQ on the edge the delay slot completes; no new redirect can be accepted in WAIT_DS.
REQ-016 SHALL otherwise advance fetch_pc<=fetch_pc+4 on each completed fetch; the add wraps modulo 2^32.
REQ-017 SHALL set is_ds_ID=1 for the instruction completing while is_bj_ID=1 and valid_ID=1 were accepted (same edge) or pending (WAIT_DS).
REQ-018 SHALL give exc_redirect absolute priority, overriding stall_ID, ready and state: fetch_pc<=exc_address, valid_ID<=0, is_ds_ID<=0, pend_pc discarded, state<=SEQ.
REQ-019 SHALL capture rdata into a one-entry skid buffer when ready=1 and stall_ID=1, deasserting inst_sram_en while the buffer is full.
REQ-020 SHALL deliver the buffered instruction on the first edge with stall_ID=0, treating it as a completed fetch.
REQ-021 SHALL flush the skid buffer on exc_redirect.

Reset
REQ-022 SHALL, while resetn=0, hold: fetch_pc=0xBFC00000, PC_ID=0, inst_ID=0, valid_ID=0, is_ds_ID=0, adel_ID=0, pend_pc=0, state SEQ, skid empty, inst_sram_en=0.
REQ-023 SHALL assert inst_sram_en on the first clk edge after resetn rises.
REQ-024 SHALL abort a reset asserted mid-WAIT_DS or mid-stall immediately, with no pending redirect surviving.

Configuration
REQ-025 SHALL, with PC_ALIGN_CHECK_EN defined, handle any fetch_pc with [1:0]!=0 as follows: inst_sram_en=0, complete without waiting for ready, set adel_ID=1, PC_ID=fetch_pc, inst_ID=0, then hold fetch_pc until exc_redirect.
REQ-026 SHALL, without PC_ALIGN_CHECK_EN, tie adel_ID to 0 and present fetch_pc unmodified.

Structure
REQ-027 SHALL place the reset vector 0xBFC00000 and the SEQ/WAIT_DS state encoding in the shared package cpu_pkg.
REQ-028 SHALL implement the skid buffer as sub-module fetch_skid_buf.

Verification
REQ-029 SHALL cover reset release: the first fetch is 0xBFC00000 and the next is 0xBFC00004, with ready always 1.
REQ-030 SHALL cover a branch at 0xBFC00010 with target 0xBFC00100 and the delay slot ready: ID sequence 0xBFC00010, 0xBFC00014 (is_ds=1), 0xBFC00100.
REQ-031 SHALL cover the same branch with ready=0 for 3 cycles: the bench sees WAIT_DS, ID gets bubbles, then 0xBFC00014 (is_ds=1), then 0xBFC00100.
REQ-032 SHALL cover stall_ID=1 for 2 cycles while ready=1: no instruction is lost or duplicated after release, and inst_sram_en=0 while the skid is full.
REQ-033 SHALL cover exc_redirect to 0xBFC00380 during WAIT_DS with stall_ID=1: pend_pc is dropped and the next completed fetch is 0xBFC00380.
REQ-034 SHALL cover PC_ALIGN_CHECK_EN defined with BJ_address=0xBFC00102: the next ID result is adel_ID=1 and PC_ID=0xBFC00102.
